// File: rtl/cordic_pkg.sv
// cordic_pkg: CORDIC constants in Q2.30 and a width-rescaling helper.
// Exports ATAN_TABLE, K_Q30, ANGLE_LIMIT_Q30 and rescale_q30().
package cordic_pkg;

  localparam logic signed [31:0] ATAN_TABLE [0:31] = '{
    32'sd843314857, 32'sd497837829, 32'sd263043837,
    32'sd133525159, 32'sd67021687,  32'sd33543516,
    32'sd16775851,  32'sd8388437,   32'sd4194283,
    32'sd2097149,   32'sd1048576,   32'sd524288,
    32'sd262144,    32'sd131072,    32'sd65536,
    32'sd32768,     32'sd16384,     32'sd8192,
    32'sd4096,      32'sd2048,      32'sd1024,
    32'sd512,       32'sd256,       32'sd128,
    32'sd64,        32'sd32,        32'sd16,
    32'sd8,         32'sd4,         32'sd2,
    32'sd1,         32'sd0
  };

  localparam logic signed [31:0] K_Q30 = 32'sd652032874;
  localparam logic signed [31:0] ANGLE_LIMIT_Q30 =
    32'sd1610612736;

  // Re-express a Q2.30 value with fw fraction bits,
  // rounding half-up when bits are dropped.
  function automatic logic signed [63:0] rescale_q30(
    input logic signed [31:0] v,
    input int                 fw
  );
    logic signed [63:0] w;
    w = {{32{v[31]}}, v};
    if (fw >= 30) return w <<< (fw - 30);
    return (w + (64'sd1 <<< (29 - fw))) >>> (30 - fw);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one registered CORDIC micro-rotation by 2^-SHIFT.
// Ports: clock/aclr/clk_en; x,y,z,vld,tag,err in; xr..errr out.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT = 0,
  parameter int IW    = 24,
  parameter int TAG_W = 4,
  parameter logic signed [IW-1:0] ATAN_VAL = '0
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 clk_en,
  input  logic signed [IW-1:0] x,
  input  logic signed [IW-1:0] y,
  input  logic signed [IW-1:0] z,
  input  logic                 vld,
  input  logic [TAG_W-1:0]     tag,
  input  logic                 err,
  output logic signed [IW-1:0] xr,
  output logic signed [IW-1:0] yr,
  output logic signed [IW-1:0] zr,
  output logic                 vldr,
  output logic [TAG_W-1:0]     tagr,
  output logic                 errr
);

  logic                 neg;
  logic signed [IW-1:0] xs;
  logic signed [IW-1:0] ys;

  assign neg = z[IW-1];
  assign xs  = x >>> SHIFT;
  assign ys  = y >>> SHIFT;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      xr   <= '0;
      yr   <= '0;
      zr   <= '0;
      vldr <= 1'b0;
      tagr <= '0;
      errr <= 1'b0;
    end else if (clk_en) begin
      xr   <= neg ? x + ys : x - ys;
      yr   <= neg ? y - xs : y + xs;
      zr   <= neg ? z + ATAN_VAL : z - ATAN_VAL;
      vldr <= vld;
      tagr <= tag;
      errr <= err;
    end
  end

endmodule

// File: rtl/cordic_sincos_pipe.sv
// cordic_sincos_pipe: pipelined CORDIC cos/sin, Q2.(DATA_W-2).
// Ports: clock/aclr/clk_en, in_valid/angle/in_tag -> out_*.
module cordic_sincos_pipe
  import cordic_pkg::*;
#(
  parameter int DATA_W = 22,
  parameter int STAGES = 16,
  parameter int TAG_W  = 4
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              clk_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] angle,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] cos_out,
  output logic [DATA_W-1:0] sin_out,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int IW = DATA_W + 2;

  localparam logic signed [DATA_W-1:0] K_SCALED =
    DATA_W'(rescale_q30(K_Q30, DATA_W - 2));
  localparam logic signed [DATA_W-1:0] LIM =
    DATA_W'(rescale_q30(ANGLE_LIMIT_Q30, DATA_W - 2));
  localparam logic signed [DATA_W-1:0] NLIM = -LIM;

  logic signed [IW-1:0] xs [0:STAGES];
  logic signed [IW-1:0] ys [0:STAGES];
  logic signed [IW-1:0] zs [0:STAGES];
  logic                 vs [0:STAGES];
  logic [TAG_W-1:0]     ts [0:STAGES];
  logic                 es [0:STAGES];

  logic signed [DATA_W-1:0] a;
  logic                     range_err;

  assign a         = angle;
  assign range_err = (a > LIM) || (a < NLIM);

  // Out-of-range angles rotate by zero so the
  // sample still lands as cos 1, sin 0.
  assign xs[0] = {K_SCALED, 2'b00};
  assign ys[0] = '0;
  assign zs[0] = range_err ? '0 : {a, 2'b00};
  assign vs[0] = in_valid;
  assign ts[0] = in_tag;
  assign es[0] = range_err;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam logic signed [IW-1:0] AV =
      IW'(rescale_q30(ATAN_TABLE[i], DATA_W));
    cordic_stage #(
      .SHIFT   (i),
      .IW      (IW),
      .TAG_W   (TAG_W),
      .ATAN_VAL(AV)
    ) u_stage (
      .clock (clock),
      .aclr  (aclr),
      .clk_en(clk_en),
      .x     (xs[i]),
      .y     (ys[i]),
      .z     (zs[i]),
      .vld   (vs[i]),
      .tag   (ts[i]),
      .err   (es[i]),
      .xr    (xs[i+1]),
      .yr    (ys[i+1]),
      .zr    (zs[i+1]),
      .vldr  (vs[i+1]),
      .tagr  (ts[i+1]),
      .errr  (es[i+1])
    );
  end

  // Drop the guard bits (round half-up) and clamp.
  function automatic logic [DATA_W-1:0] rnd_sat(
    input logic signed [IW-1:0] v
  );
    logic signed [IW:0]   s;
    logic signed [IW-2:0] r;
    s = {v[IW-1], v} + {{(IW-1){1'b0}}, 2'b10};
    r = (IW-1)'(s >>> 2);
    if (r[IW-2] != r[IW-3]) begin
      if (r[IW-2]) return {1'b1, {(DATA_W-1){1'b0}}};
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
    return r[DATA_W-1:0];
  endfunction

  assign cos_out   = rnd_sat(xs[STAGES]);
  assign sin_out   = rnd_sat(ys[STAGES]);
  assign out_valid = vs[STAGES];
  assign out_tag   = ts[STAGES];
  assign out_err   = es[STAGES];

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// tb_cordic_sincos_pipe: scoreboard bench for two configurations
// (22b/16 stages and 16b/12 stages) driven in lock-step.
module tb_cordic_sincos_pipe;

  localparam int W1 = 22;
  localparam int S1 = 16;
  localparam int W2 = 16;
  localparam int S2 = 12;
  localparam int TW = 4;
  localparam int TB1 = 48;
  localparam int TB2 = 24;

  logic          clock = 1'b0;
  logic          aclr = 1'b1;
  logic          clk_en = 1'b1;
  logic          in_valid = 1'b0;
  logic [W1-1:0] angle = '0;
  logic [W2-1:0] angle2 = '0;
  logic [TW-1:0] in_tag = '0;

  logic          ov1, er1, ov2, er2;
  logic [W1-1:0] c1, s1;
  logic [W2-1:0] c2, s2;
  logic [TW-1:0] t1, t2;

  cordic_sincos_pipe #(
    .DATA_W(W1), .STAGES(S1), .TAG_W(TW)
  ) u_dut1 (
    .clock(clock), .aclr(aclr), .clk_en(clk_en),
    .in_valid(in_valid), .angle(angle), .in_tag(in_tag),
    .out_valid(ov1), .cos_out(c1), .sin_out(s1),
    .out_tag(t1), .out_err(er1)
  );

  cordic_sincos_pipe #(
    .DATA_W(W2), .STAGES(S2), .TAG_W(TW)
  ) u_dut2 (
    .clock(clock), .aclr(aclr), .clk_en(clk_en),
    .in_valid(in_valid), .angle(angle2), .in_tag(in_tag),
    .out_valid(ov2), .cos_out(c2), .sin_out(s2),
    .out_tag(t2), .out_err(er2)
  );

  typedef struct {
    int  tag;
    int  c;
    int  s;
    int  e;
    int  en;
    int  raw;
    int  dis;
    int  mono;
    real tc;
    real ts;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  int tests = 0;
  int fails = 0;
  int raw_cnt = 0;
  int en_cnt = 0;
  int dis_cnt = 0;
  bit adv = 1'b0;
  int prev_c [2];
  int last_c [2];
  int last_t [2];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    raw_cnt <= raw_cnt + 1;
    if (!aclr) begin
      if (clk_en) en_cnt <= en_cnt + 1;
      else        dis_cnt <= dis_cnt + 1;
    end
    adv <= clk_en && !aclr;
  end

  task automatic check(
    input string  tag,
    input longint obs,
    input longint exp,
    input longint tol
  );
    longint d;
    tests++;
    d = (obs > exp) ? obs - exp : exp - obs;
    if (d > tol) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)",
               tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Ideal real-valued CORDIC with the same iteration count.
  function automatic void model(
    input  real a,
    input  int  stg,
    input  int  fw,
    output int  c,
    output int  s
  );
    real x, y, z, xn, p, sc;
    x = 0.6072529350;
    y = 0.0;
    z = a;
    p = 1.0;
    for (int i = 0; i < stg; i++) begin
      if (z >= 0.0) begin
        xn = x - y * p;
        y  = y + x * p;
        z  = z - $atan(p);
      end else begin
        xn = x + y * p;
        y  = y - x * p;
        z  = z + $atan(p);
      end
      x = xn;
      p = p / 2.0;
    end
    sc = real'(longint'(1) << fw);
    c = rnd(x * sc);
    s = rnd(y * sc);
  endfunction

  function automatic void build(
    input  real  a,
    input  int   tag,
    input  int   mono,
    input  int   w,
    input  int   stg,
    output exp_t x,
    output int   ai
  );
    real sc, aq;
    bit  err;
    int  c, s;
    sc  = real'(longint'(1) << (w - 2));
    ai  = rnd(a * sc);
    aq  = real'(ai) / sc;
    err = (aq > 1.5) || (aq < -1.5);
    model(err ? 0.0 : aq, stg, w - 2, c, s);
    x.tag  = tag & 15;
    x.c    = c;
    x.s    = s;
    x.e    = int'(err);
    x.en   = en_cnt + stg;
    x.raw  = raw_cnt;
    x.dis  = dis_cnt;
    x.mono = mono;
    x.tc   = err ? sc : $cos(aq) * sc;
    x.ts   = err ? 0.0 : $sin(aq) * sc;
  endfunction

  task automatic score(
    input int d,
    input int t,
    input int c,
    input int s,
    input int e
  );
    exp_t  x;
    string p;
    int    stg, bnd;
    p   = (d == 0) ? "d1" : "d2";
    stg = (d == 0) ? S1 : S2;
    bnd = (d == 0) ? TB1 : TB2;
    if (d == 0) begin
      if (q1.size() == 0) begin
        check({p, "_spurious"}, 1, 0, 0);
        return;
      end
      x = q1.pop_front();
    end else begin
      if (q2.size() == 0) begin
        check({p, "_spurious"}, 1, 0, 0);
        return;
      end
      x = q2.pop_front();
    end
    check({p, "_tag"}, t, x.tag, 0);
    check({p, "_cos"}, c, x.c, 16);
    check({p, "_sin"}, s, x.s, 16);
    check({p, "_err"}, e, x.e, 0);
    check({p, "_lat_en"}, en_cnt, x.en, 0);
    check({p, "_lat_raw"}, raw_cnt - x.raw,
          stg + dis_cnt - x.dis, 0);
    check({p, "_cos_true"}, c, rnd(x.tc), bnd);
    check({p, "_sin_true"}, s, rnd(x.ts), bnd);
    if (x.mono == 2)
      check({p, "_cos_mono"}, longint'(c < prev_c[d]), 1, 0);
    if (x.mono > 0) prev_c[d] = c;
    last_c[d] = x.c;
    last_t[d] = x.tag;
  endtask

  always @(negedge clock) begin
    if (adv && !aclr) begin
      if (ov1) begin
        score(0, int'(t1), int'($signed(c1)),
              int'($signed(s1)), int'(er1));
      end else if (q1.size() > 0 && q1[0].en <= en_cnt) begin
        check("d1_missing", 0, 1, 0);
        void'(q1.pop_front());
      end
      if (ov2) begin
        score(1, int'(t2), int'($signed(c2)),
              int'($signed(s2)), int'(er2));
      end else if (q2.size() > 0 && q2[0].en <= en_cnt) begin
        check("d2_missing", 0, 1, 0);
        void'(q2.pop_front());
      end
    end
  end

  task automatic send(
    input real a,
    input int  tag,
    input int  mono
  );
    exp_t x;
    int   ai;
    @(negedge clock);
    build(a, tag, mono, W1, S1, x, ai);
    q1.push_back(x);
    angle = W1'(ai);
    build(a, tag, mono, W2, S2, x, ai);
    q2.push_back(x);
    angle2 = W2'(ai);
    in_tag = TW'(tag);
    in_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic stream();
    for (int k = 0; k <= 10; k++)
      send(0.1 * k, k, (k == 0) ? 1 : 2);
  endtask

  task automatic check_zero(input string p);
    check({p, "_valid1"}, ov1, 0, 0);
    check({p, "_cos1"}, c1, 0, 0);
    check({p, "_sin1"}, s1, 0, 0);
    check({p, "_tag1"}, t1, 0, 0);
    check({p, "_err1"}, er1, 0, 0);
    check({p, "_valid2"}, ov2, 0, 0);
    check({p, "_cos2"}, c2, 0, 0);
  endtask

  task automatic stall3();
    @(negedge clock);
    clk_en = 1'b0;
    in_valid = 1'b1;
    angle = 22'h05A5A5;
    angle2 = 16'h1234;
    repeat (3) begin
      @(negedge clock);
      check("stall_valid1", ov1, 1, 0);
      check("stall_tag1", t1, last_t[0], 0);
      check("stall_cos1", int'($signed(c1)), last_c[0], 16);
      check("stall_valid2", ov2, 1, 0);
      check("stall_cos2", int'($signed(c2)), last_c[1], 16);
    end
    clk_en = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic reset_mid();
    for (int k = 0; k < 5; k++) send(0.2 * k, k, 0);
    @(posedge clock);
    #2;
    aclr = 1'b1;
    q1.delete();
    q2.delete();
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("rst_hold");
    aclr = 1'b0;
    in_valid = 1'b0;
    send(0.3, 5, 0);
    idle(25);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, got t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b1;
    repeat (3) @(negedge clock);
    check_zero("rst_init");
    aclr = 1'b0;

    send(0.0, 1, 0);
    idle(20);
    send(1.0, 2, 0);
    send(-1.0, 3, 0);
    idle(20);

    stream();
    idle(22);

    stream();
    idle(8);
    stall3();
    idle(22);

    send(1.625, 7, 0);
    send(0.5, 8, 0);
    send(1.5, 9, 0);
    send(1.5 + 1.0 / 1048576.0, 10, 0);
    send(-1.5, 11, 0);
    send(-1.5 - 1.0 / 1048576.0, 12, 0);
    idle(22);

    reset_mid();

    check("d1_drain", q1.size(), 0, 0);
    check("d2_drain", q2.size(), 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_sincos_pipe.md
# cordic_sincos_pipe

Parametrised, fully pipelined CORDIC rotator producing both cosine and sine of a signed fixed-point angle, one result per enabled clock. It is the next generation of the fixed-width cosine-only pipeline: data width and stage count are parameters, a valid bit and user tag travel with each sample, and out-of-range angles are flagged. It sits behind the float-to-fixed front end and ahead of the fixed-to-float converter inside the custom-instruction accelerator.

## Interface
- DATA_W, 22: width of angle/cos/sin, signed Q2.(DATA_W-2); legal 12..32
- STAGES, 16: CORDIC iterations, one pipeline stage each; legal 8..min(30, DATA_W-2)
- TAG_W, 4: width of opaque tag carried alongside each sample; legal 1..8
- clock  in  1  sole clock, rising edge
- aclr  in  1  asynchronous, active-high reset
- clk_en  in  1  global advance enable; low freezes the entire pipeline
- in_valid  in  1  angle/in_tag are a sample this cycle
- angle  in  DATA_W  signed Q2.(DATA_W-2) radians
- in_tag  in  TAG_W  opaque, returned unchanged with result
- out_valid  out  1  cos_out/sin_out/out_tag/out_err are valid
- cos_out  out  DATA_W  signed Q2.(DATA_W-2) cosine
- sin_out  out  DATA_W  signed Q2.(DATA_W-2) sine
- out_tag  out  TAG_W  tag of the sample now at output
- out_err  out  1  sample's |angle| exceeded 1.5 rad

## Operation
- Seed (combinational, feeds stage 0): x0 = K_SCALED (0.6072529350 rounded to DATA_W-2 frac bits), y0 = 0, z0 = angle; err = (angle > +1.5) or (angle < -1.5).
- If err: z0 forced to 0 (result is cos 1, sin 0, out_err=1); never wraps or saturates mid-pipe.
- Stage i (0..STAGES-1): d = (z >= 0) ? +1 : -1; x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*ATAN[i].
- Shifts are arithmetic; internal x/y/z carry 2 guard LSBs (DATA_W+2 bits); final stage output rounds half-up back to DATA_W, then saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- ATAN[i] = round(atan(2^-i) * 2^30) from the package, right-shifted with rounding to the internal fraction width.
- valid, tag, err travel in shift registers parallel to x/y/z, same depth.
- Invalid samples still flow (don't-care data) but carry valid=0; out_valid=0 for them.

## Timing
- Latency: exactly STAGES rising edges with clk_en=1 from sample accepted to out_valid=1.
- Throughput: one sample per enabled cycle, no backpressure, no bubbles required.
- clk_en=0: every register holds, including out_valid and outputs; in_valid ignored that cycle.
- aclr=1 (any time, async): all stage registers, valid chain, outputs clear to 0 immediately; out_valid=0, cos_out=sin_out=0, out_tag=0, out_err=0.
- Reset mid-stream: in-flight samples discarded; first out_valid after release is the first sample accepted after release, STAGES enabled edges later.
- in_valid with aclr high: ignored.

## Structure
- Package cordic_pkg: ATAN_TABLE[0:31] (Q2.30 constants), K_Q30 = 0.6072529350 in Q2.30, ANGLE_LIMIT_Q30 = 1.5 in Q2.30, width-rescaling function.
- Sub-module cordic_stage (parameters SHIFT, IW, ATAN_VAL): one registered micro-rotation with valid/tag/err pass-through and clk_en/aclr; top generates STAGES instances.
- Top holds seed logic, range check, output rounding/saturation.

## Test plan
- Defaults; angle 0x000000 -> cos_out 0x100000 ±16 LSB, sin_out 0x000000 ±16, out_valid high exactly 16 enabled cycles later.
- angle 0x100000 (1.0) -> cos 0x08A517 ±16, sin 0x0D76B0 ±16; angle 0x300000 (-1.0) -> cos 0x08A517, sin -0x0D76B0 (0x3289 50) ±16.
- Stream 11 angles 0.0..1.0 step 0.1 back-to-back with tags 0..10 -> 11 consecutive out_valid cycles, tags in order, cos monotonic decreasing, each within ±16 LSB of reference.
- Same stream with clk_en low for 3 cycles mid-flight -> outputs frozen during stall, same ordered results, total latency 16 + 3 cycles.
- angle 0x1A0000 (1.625) tag 7 -> out_err=1, cos 0x100000±16, sin 0, out_tag 7; next sample 0x080000 unaffected (out_err=0).
- aclr pulsed with 5 samples in flight -> outputs 0 immediately, no stale out_valid; new sample after release appears 16 cycles later. Repeat with DATA_W=16, STAGES=12.
